// File: rtl/descriptor_serializer.sv
// descriptor_serializer
//
// Buffers descriptor records (32-bit keypoint + four 16-bit channels) in a
// record FIFO. It sends each record MSB-first as 12 bytes on an 8-bit
// valid/ready stream. Each frame ends with the 4-byte trailer
// A5 5A count_hi count_lo, where count is the number of records accepted in
// the frame. Records that arrive while the FIFO is full, or after the frame
// was closed, are dropped and flagged on a sticky overflow bit.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   descriptor_valid  strobe: keypoint_value/channel1..4 valid this cycle
//   keypoint_value    32-bit keypoint word
//   channel1..4       16-bit descriptor channels
//   descriptor_done   strobe: no more records in this frame
//   out_data          serialized byte (registered)
//   out_valid         out_data valid
//   out_ready         sink accepts the byte when out_valid & out_ready
//   overflow          sticky: a record was dropped in this frame
//   frame_done        one-cycle pulse after the last trailer byte is accepted
//   busy              activity pending: not idle, FIFO non-empty, or frame closing
module descriptor_serializer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        descriptor_valid,
    input  logic [31:0] keypoint_value,
    input  logic [15:0] channel1,
    input  logic [15:0] channel2,
    input  logic [15:0] channel3,
    input  logic [15:0] channel4,
    input  logic        descriptor_done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        frame_done,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]  LAST_REC_BYTE = 4'd11;
    localparam logic [3:0]  LAST_TRL_BYTE = 4'd3;
    localparam logic [15:0] TRAILER_SYNC  = 16'hA55A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        TRAILER = 2'd2
    } state_t;

    // Record packing: keypoint in the top word, then channel1..channel4.
    logic [95:0] record_in;
    logic [15:0] channels [4];

    assign channels[0] = channel1;
    assign channels[1] = channel2;
    assign channels[2] = channel3;
    assign channels[3] = channel4;
    assign record_in[95:64] = keypoint_value;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign record_in[63 - 16*gi -: 16] = channels[gi];
        end
    endgenerate

    // Record FIFO storage. The shift register below is the registered read
    // port: the head is read at the clock edge that pops it.
    logic [95:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] fifo_count_reg;
    logic [CW-1:0] fifo_count_next;

    state_t        state_reg;
    logic [95:0]   shift_reg;      // byte on the wire is always the top byte
    logic [3:0]    index_reg;
    logic [15:0]   count_reg;
    logic          done_pending_reg;
    logic          overflow_reg;
    logic          out_valid_reg;
    logic          frame_done_reg;

    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic last_byte;
    logic pop;
    logic wr_en;
    logic [95:0] trailer_word;

    assign fifo_empty = (fifo_count_reg == '0);
    assign fifo_full  = (fifo_count_reg == CW'(DEPTH));
    assign accept     = out_valid_reg & out_ready;
    assign last_byte  = (state_reg == TRAILER) ? (index_reg == LAST_TRL_BYTE)
                                               : (index_reg == LAST_REC_BYTE);

    // Pop when idle, or when the last byte of a record is taken. This gives
    // back-to-back records with no bubble.
    assign pop = !fifo_empty &&
                 ((state_reg == IDLE) ||
                  (state_reg == SEND && accept && index_reg == LAST_REC_BYTE));

    // Fullness counts the same-cycle pop, so a full FIFO being drained still
    // takes a new record.
    assign wr_en = descriptor_valid && !done_pending_reg && (!fifo_full || pop);

    assign trailer_word = {TRAILER_SYNC, count_reg, 64'd0};

    always_comb begin
        fifo_count_next = fifo_count_reg;
        case ({wr_en, pop})
            2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
            2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
            default: fifo_count_next = fifo_count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= record_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fifo_count_reg   <= '0;
            state_reg        <= IDLE;
            shift_reg        <= '0;
            index_reg        <= '0;
            count_reg        <= '0;
            done_pending_reg <= 1'b0;
            overflow_reg     <= 1'b0;
            out_valid_reg    <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            fifo_count_reg <= fifo_count_next;

            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (count_reg != 16'hFFFF) begin
                    count_reg <= count_reg + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (descriptor_valid && !wr_en) begin
                overflow_reg <= 1'b1;
            end
            if (descriptor_done) begin
                done_pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg     <= mem[rd_ptr_reg];
                        index_reg     <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= SEND;
                    end else if (done_pending_reg) begin
                        // No writes happen while done is pending, so count is final.
                        shift_reg     <= trailer_word;
                        index_reg     <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= TRAILER;
                    end
                end

                SEND: begin
                    if (accept) begin
                        if (!last_byte) begin
                            index_reg <= index_reg + 4'd1;
                            shift_reg <= {shift_reg[87:0], 8'd0};
                        end else if (!fifo_empty) begin
                            shift_reg <= mem[rd_ptr_reg];
                            index_reg <= '0;
                        end else if (done_pending_reg) begin
                            shift_reg <= trailer_word;
                            index_reg <= '0;
                            state_reg <= TRAILER;
                        end else begin
                            out_valid_reg <= 1'b0;
                            state_reg     <= IDLE;
                        end
                    end
                end

                TRAILER: begin
                    if (accept) begin
                        if (!last_byte) begin
                            index_reg <= index_reg + 4'd1;
                            shift_reg <= {shift_reg[87:0], 8'd0};
                        end else begin
                            // End of frame: clear the per-frame state.
                            frame_done_reg   <= 1'b1;
                            count_reg        <= '0;
                            overflow_reg     <= 1'b0;
                            done_pending_reg <= 1'b0;
                            out_valid_reg    <= 1'b0;
                            state_reg        <= IDLE;
                        end
                    end
                end

                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign out_data   = shift_reg[95:88];
    assign out_valid  = out_valid_reg;
    assign overflow   = overflow_reg;
    assign frame_done = frame_done_reg;
    assign busy       = (state_reg != IDLE) || !fifo_empty || done_pending_reg;

endmodule

// File: tb/tb_descriptor_serializer.sv
// Testbench for descriptor_serializer. A reference model builds the expected
// byte stream from each record's fields and from each frame's accepted-record
// count. The bench compares that stream with the bytes the sink accepts.
module tb_descriptor_serializer;

    logic        clk;
    logic        rst;
    logic        descriptor_valid;
    logic [31:0] keypoint_value;
    logic [15:0] channel1;
    logic [15:0] channel2;
    logic [15:0] channel3;
    logic [15:0] channel4;
    logic        descriptor_done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        frame_done;
    logic        busy;

    descriptor_serializer #(.DEPTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .descriptor_valid (descriptor_valid),
        .keypoint_value   (keypoint_value),
        .channel1         (channel1),
        .channel2         (channel2),
        .channel3         (channel3),
        .channel4         (channel4),
        .descriptor_done  (descriptor_done),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .overflow         (overflow),
        .frame_done       (frame_done),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Sink-side monitor state
    logic [7:0] captured [$];
    logic [7:0] expected [$];
    int         neg_cyc = 0;
    int         fd_count = 0;
    int         fd_cyc = 0;
    int         last_accept_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // out_ready driving: 0 = always 1, 1 = pattern 1,0,0,1, 2 = random, 3 = always 0
    int ready_mode = 0;
    int pat_idx = 0;

    always @(negedge clk) begin
        neg_cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold valid=%b data=%02h required valid=1 data=%02h",
                             out_valid, out_data, prev_data);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                captured.push_back(out_data);
                last_accept_cyc = neg_cyc;
            end
            if (frame_done === 1'b1) begin
                fd_count++;
                fd_cyc = neg_cyc;
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_data  = out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
                pat_idx++;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic drive_record(input logic [31:0] kp, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] c,
                                input logic [15:0] d);
        descriptor_valid = 1'b1;
        keypoint_value   = kp;
        channel1 = a;
        channel2 = b;
        channel3 = c;
        channel4 = d;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && captured.size() < n; i++) step();
    endtask

    task automatic wait_frame_done(input int start, input int budget);
        for (int i = 0; i < budget && fd_count == start; i++) step();
        step();
        step();
    endtask

    // ---------------- reference model ----------------
    task automatic model_record(input logic [31:0] kp, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] c,
                                input logic [15:0] d);
        logic [15:0] ch [4];
        ch[0] = a; ch[1] = b; ch[2] = c; ch[3] = d;
        for (int k = 0; k < 4; k++) expected.push_back(8'((kp >> (24 - 8*k)) & 32'hFF));
        for (int k = 0; k < 4; k++) begin
            expected.push_back(8'(ch[k] / 256));
            expected.push_back(8'(ch[k] % 256));
        end
    endtask

    task automatic model_trailer(input int count);
        expected.push_back(8'hA5);
        expected.push_back(8'h5A);
        expected.push_back(8'((count / 256) % 256));
        expected.push_back(8'(count % 256));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        ready_mode = 0;
        step(); step(); step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || overflow !== 1'b0 ||
            frame_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state valid=%b data=%02h ovf=%b fd=%b busy=%b required all zero",
                     out_valid, out_data, overflow, frame_done, busy);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single_record();
        int fd0;
        ready_mode = 0;
        step();
        captured.delete();
        expected.delete();
        fd0 = fd_count;
        model_record(32'h11223344, 16'hAABB, 16'hCCDD, 16'hEEFF, 16'h0102);
        model_trailer(1);
        drive_record(32'h11223344, 16'hAABB, 16'hCCDD, 16'hEEFF, 16'h0102);
        step();
        descriptor_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency_t1 valid=%b required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            failures++;
            $display("FAIL single_latency_t2 valid=%b data=%02h required valid=1 data=11",
                     out_valid, out_data);
        end
        wait_bytes(12, 100);
        descriptor_done = 1'b1;
        step();
        descriptor_done = 1'b0;
        wait_frame_done(fd0, 100);
        checks++;
        if (captured.size() != expected.size()) begin
            failures++;
            $display("FAIL single_len got=%0d required=%0d", captured.size(), expected.size());
        end
        for (int i = 0; i < expected.size() && i < captured.size(); i++) begin
            checks++;
            if (captured[i] !== expected[i]) begin
                failures++;
                $display("FAIL single_byte[%0d] got=%02h required=%02h", i, captured[i], expected[i]);
            end
        end
        checks++;
        if (fd_count != fd0 + 1) begin
            failures++;
            $display("FAIL single_frame_done pulses=%0d required=1", fd_count - fd0);
        end
        $display("single_record: %0d bytes received", captured.size());
    endtask

    task automatic test_backpressure();
        int fd0;
        ready_mode = 1;
        pat_idx = 0;
        step();
        captured.delete();
        expected.delete();
        fd0 = fd_count;
        model_record(32'h11223344, 16'hAABB, 16'hCCDD, 16'hEEFF, 16'h0102);
        model_trailer(1);
        drive_record(32'h11223344, 16'hAABB, 16'hCCDD, 16'hEEFF, 16'h0102);
        step();
        descriptor_valid = 1'b0;
        descriptor_done  = 1'b1;
        step();
        descriptor_done  = 1'b0;
        wait_frame_done(fd0, 200);
        checks++;
        if (captured.size() != expected.size()) begin
            failures++;
            $display("FAIL bp_len got=%0d required=%0d", captured.size(), expected.size());
        end
        for (int i = 0; i < expected.size() && i < captured.size(); i++) begin
            checks++;
            if (captured[i] !== expected[i]) begin
                failures++;
                $display("FAIL bp_byte[%0d] got=%02h required=%02h", i, captured[i], expected[i]);
            end
        end
        $display("backpressure: %0d bytes received", captured.size());
    endtask

    task automatic test_overflow();
        logic [31:0] kp [18];
        logic [15:0] ch [18][4];
        int fd0;
        ready_mode = 3;
        step();
        captured.delete();
        expected.delete();
        fd0 = fd_count;
        for (int i = 0; i < 18; i++) begin
            kp[i] = $urandom;
            for (int k = 0; k < 4; k++) ch[i][k] = 16'($urandom);
            if (i < 17) model_record(kp[i], ch[i][0], ch[i][1], ch[i][2], ch[i][3]);
        end
        model_trailer(17);
        for (int i = 0; i < 18; i++) begin
            drive_record(kp[i], ch[i][0], ch[i][1], ch[i][2], ch[i][3]);
            @(negedge clk);
            if (i == 17) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_before_18 overflow=%b required 0", overflow);
                end
            end
            step();
        end
        descriptor_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_after_18 overflow=%b required 1", overflow);
        end
        step();
        descriptor_done = 1'b1;
        step();
        descriptor_done = 1'b0;
        ready_mode = 0;
        wait_frame_done(fd0, 600);
        checks++;
        if (captured.size() != expected.size()) begin
            failures++;
            $display("FAIL ovf_len got=%0d required=%0d", captured.size(), expected.size());
        end
        for (int i = 0; i < expected.size() && i < captured.size(); i++) begin
            checks++;
            if (captured[i] !== expected[i]) begin
                failures++;
                $display("FAIL ovf_byte[%0d] got=%02h required=%02h", i, captured[i], expected[i]);
            end
        end
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b0 || fd_count != fd0 + 1) begin
            failures++;
            $display("FAIL ovf_end overflow=%b busy=%b pulses=%0d required 0 0 1",
                     overflow, busy, fd_count - fd0);
        end
        $display("overflow: %0d bytes received", captured.size());
    endtask

    task automatic test_empty_frame();
        int fd0;
        ready_mode = 0;
        step();
        captured.delete();
        expected.delete();
        fd0 = fd_count;
        model_trailer(0);
        descriptor_done = 1'b1;
        step();
        descriptor_done = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL empty_t1 valid=%b busy=%b required valid=0 busy=1", out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            failures++;
            $display("FAIL empty_t2 valid=%b data=%02h required valid=1 data=a5", out_valid, out_data);
        end
        wait_frame_done(fd0, 100);
        checks++;
        if (captured.size() != expected.size()) begin
            failures++;
            $display("FAIL empty_len got=%0d required=%0d", captured.size(), expected.size());
        end
        for (int i = 0; i < expected.size() && i < captured.size(); i++) begin
            checks++;
            if (captured[i] !== expected[i]) begin
                failures++;
                $display("FAIL empty_byte[%0d] got=%02h required=%02h", i, captured[i], expected[i]);
            end
        end
        checks++;
        if (fd_count != fd0 + 1 || fd_cyc != last_accept_cyc + 1) begin
            failures++;
            $display("FAIL empty_frame_done pulses=%0d delay=%0d required pulses=1 delay=1",
                     fd_count - fd0, fd_cyc - last_accept_cyc);
        end
        $display("empty_frame: %0d bytes received", captured.size());
    endtask

    task automatic test_valid_and_done();
        int fd0;
        ready_mode = 0;
        step();
        captured.delete();
        expected.delete();
        fd0 = fd_count;
        model_record(32'hDEADBEEF, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        model_record(32'hCAFEF00D, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
        model_trailer(2);
        drive_record(32'hDEADBEEF, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        step();
        drive_record(32'hCAFEF00D, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
        descriptor_done = 1'b1;
        step();
        descriptor_valid = 1'b0;
        descriptor_done  = 1'b0;
        step(); step();
        drive_record(32'h55555555, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step();
        descriptor_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL vd_third_dropped overflow=%b required 1", overflow);
        end
        wait_frame_done(fd0, 200);
        checks++;
        if (captured.size() != expected.size()) begin
            failures++;
            $display("FAIL vd_len got=%0d required=%0d", captured.size(), expected.size());
        end
        for (int i = 0; i < expected.size() && i < captured.size(); i++) begin
            checks++;
            if (captured[i] !== expected[i]) begin
                failures++;
                $display("FAIL vd_byte[%0d] got=%02h required=%02h", i, captured[i], expected[i]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL vd_ovf_clear overflow=%b required 0", overflow);
        end
        $display("valid_and_done: %0d bytes received", captured.size());
    endtask

    task automatic test_reset_mid();
        int fd0;
        ready_mode = 0;
        step();
        captured.delete();
        for (int i = 0; i < 4; i++) begin
            drive_record($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            step();
        end
        descriptor_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (captured.size() >= 6) break;
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state valid=%b busy=%b required 0 0", out_valid, busy);
        end
        captured.delete();
        expected.delete();
        fd0 = fd_count;
        model_record(32'h0BADC0DE, 16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2);
        model_trailer(1);
        step();
        drive_record(32'h0BADC0DE, 16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2);
        step();
        descriptor_valid = 1'b0;
        descriptor_done  = 1'b1;
        step();
        descriptor_done  = 1'b0;
        wait_frame_done(fd0, 200);
        checks++;
        if (captured.size() != expected.size()) begin
            failures++;
            $display("FAIL rstmid_len got=%0d required=%0d", captured.size(), expected.size());
        end
        for (int i = 0; i < expected.size() && i < captured.size(); i++) begin
            checks++;
            if (captured[i] !== expected[i]) begin
                failures++;
                $display("FAIL rstmid_byte[%0d] got=%02h required=%02h", i, captured[i], expected[i]);
            end
        end
        $display("reset_mid: %0d bytes received after reset", captured.size());
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            int n;
            int fd0;
            logic done_sent;
            ready_mode = 2;
            step();
            captured.delete();
            expected.delete();
            fd0 = fd_count;
            done_sent = 1'b0;
            n = $urandom_range(0, 16);
            for (int r = 0; r < n; r++) begin
                logic [31:0] kp;
                logic [15:0] a, b, c, d;
                kp = $urandom;
                a = 16'($urandom); b = 16'($urandom);
                c = 16'($urandom); d = 16'($urandom);
                model_record(kp, a, b, c, d);
                drive_record(kp, a, b, c, d);
                if (r == n - 1 && $urandom_range(0, 1) == 1) begin
                    descriptor_done = 1'b1;
                    done_sent = 1'b1;
                end
                step();
                descriptor_valid = 1'b0;
                descriptor_done  = 1'b0;
                for (int g = $urandom_range(0, 3); g > 0; g--) step();
            end
            if (!done_sent) begin
                descriptor_done = 1'b1;
                step();
                descriptor_done = 1'b0;
            end
            model_trailer(n);
            wait_frame_done(fd0, 2000);
            checks++;
            if (captured.size() != expected.size()) begin
                failures++;
                $display("FAIL rand%0d_len got=%0d required=%0d", f, captured.size(), expected.size());
            end
            for (int i = 0; i < expected.size() && i < captured.size(); i++) begin
                checks++;
                if (captured[i] !== expected[i]) begin
                    failures++;
                    $display("FAIL rand%0d_byte[%0d] got=%02h required=%02h",
                             f, i, captured[i], expected[i]);
                end
            end
            checks++;
            if (overflow !== 1'b0 || fd_count != fd0 + 1) begin
                failures++;
                $display("FAIL rand%0d_end overflow=%b pulses=%0d required 0 1",
                         f, overflow, fd_count - fd0);
            end
            $display("random frame %0d: %0d records, %0d bytes received", f, n, captured.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        descriptor_valid = 1'b0;
        descriptor_done  = 1'b0;
        keypoint_value = '0;
        channel1 = '0;
        channel2 = '0;
        channel3 = '0;
        channel4 = '0;
        out_ready = 1'b1;

        test_reset();
        test_single_record();
        test_backpressure();
        test_overflow();
        test_empty_frame();
        test_valid_and_done();
        test_reset_mid();
        test_random_frames();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
